// File: rtl/pipeline_controller.sv
// Decode and hazard controller for the 5-stage 19-bit pipeline: ID decode, shadow
// destination tracking, forwarding selects, stalls, store-data interlocks and redirects.
module pipeline_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] IF_ID_instruction,
  input  logic        C,
  input  logic        Z,
  input  logic        next_C,
  input  logic        next_Z,
  input  logic        ID_EX_alu_B_mux,
  output logic        mem_write,
  output logic        reg_write,
  output logic        push,
  output logic        pop,
  output logic        alu_use_carry,
  output logic        alu_B_mux,
  output logic        reg_B_mux,
  output logic        select_c,
  output logic        select_z,
  output logic        write_c,
  output logic        write_z,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_mux,
  output logic [1:0]  reg_write_mux,
  output logic [1:0]  forward_A,
  output logic [1:0]  forward_B,
  output logic        forward_mem_MEM,
  output logic        IF_ID_loadbar,
  output logic        pc_writebar,
  output logic        ID_EX_flush,
  output logic        IF_ID_flush
);

  typedef struct packed {
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       reg_write;
    logic       long_op;
    logic       is_ld;
    logic       st_fwd;
    logic       wc;
    logic       wz;
  } shadow_t;

  shadow_t id_ex, ex_mem, mem_wb, id_next;

  logic [2:0] op, rd, rs, rt;
  logic [1:0] sub;
  assign op  = IF_ID_instruction[18:16];
  assign sub = IF_ID_instruction[15:14];
  assign rd  = IF_ID_instruction[13:11];
  assign rs  = IF_ID_instruction[10:8];
  assign rt  = IF_ID_instruction[7:5];

  // Flags written by the instruction now in EX are not committed yet; use its results.
  logic flag_c, flag_z, br_true;
  assign flag_c = id_ex.wc ? next_C : C;
  assign flag_z = id_ex.wz ? next_Z : Z;

  always_comb begin
    case (IF_ID_instruction[13:12])
      2'b00:   br_true = flag_z;
      2'b01:   br_true = ~flag_z;
      2'b10:   br_true = flag_c;
      default: br_true = ~flag_c;
    endcase
  end

  logic       d_mem_write, d_reg_write, d_push, d_pop, d_carry, d_bmux, d_rbmux;
  logic       d_sel, d_wflags, use_rs, use_rt, is_st, is_ld, is_long;
  logic [2:0] d_alu_op;
  logic [1:0] d_pc_mux, d_rwm;

  always_comb begin
    d_mem_write = 1'b0;
    d_reg_write = 1'b0;
    d_push      = 1'b0;
    d_pop       = 1'b0;
    d_carry     = 1'b0;
    d_bmux      = 1'b0;
    d_rbmux     = 1'b0;
    d_sel       = 1'b0;
    d_wflags    = 1'b0;
    use_rs      = 1'b0;
    use_rt      = 1'b0;
    is_st       = 1'b0;
    is_ld       = 1'b0;
    is_long     = 1'b0;
    d_alu_op    = 3'b000;
    d_pc_mux    = 2'b00;
    d_rwm       = 2'b00;
    case (op)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        d_reg_write = 1'b1;
        d_alu_op    = IF_ID_instruction[16:14];
        d_wflags    = 1'b1;
        d_carry     = (d_alu_op == 3'b001) || (d_alu_op == 3'b011);
        d_bmux      = op[1];
        use_rs      = 1'b1;
        use_rt      = ~op[1];
      end
      3'b100: begin
        d_bmux      = 1'b1;
        d_reg_write = 1'b1;
        d_rwm       = 2'b10;
        use_rs      = 1'b1;
        is_ld       = 1'b1;
        is_long     = 1'b1;
      end
      3'b101: begin
        d_bmux      = 1'b1;
        d_rbmux     = 1'b1;
        d_mem_write = 1'b1;
        use_rs      = 1'b1;
        is_st       = 1'b1;
      end
      3'b110: begin
        d_reg_write = 1'b1;
        d_rwm       = 2'b01;
        d_sel       = 1'b1;
        d_wflags    = 1'b1;
        use_rs      = 1'b1;
        is_long     = 1'b1;
      end
      default: begin
        case (sub)
          2'b00: d_pc_mux = 2'b10;
          2'b01: d_pc_mux = br_true ? 2'b01 : 2'b00;
          2'b10: begin
            d_pc_mux = 2'b10;
            d_push   = 1'b1;
          end
          default: begin
            d_pc_mux = 2'b11;
            d_pop    = 1'b1;
          end
        endcase
      end
    endcase
  end

  logic load_use, st_lock, st_fwd, stall, taken;
  assign load_use = id_ex.reg_write && id_ex.long_op &&
                    ((use_rs && id_ex.rd == rs) || (use_rt && id_ex.rd == rt));
  // A store whose data comes from an older non-load result waits for it to reach WB.
  assign st_lock  = is_st &&
                    ((id_ex.reg_write && !id_ex.is_ld && id_ex.rd == rd) ||
                     (ex_mem.reg_write && ex_mem.rd == rd));
  assign st_fwd   = is_st && id_ex.reg_write && id_ex.is_ld && id_ex.rd == rd;
  assign stall    = load_use | st_lock;
  assign taken    = (d_pc_mux != 2'b00);

  function automatic logic [1:0] fwd_sel(input logic [2:0] src, input shadow_t em,
                                         input shadow_t mw);
    if (em.reg_write && !em.long_op && em.rd == src) return 2'b10;
    if (mw.reg_write && mw.rd == src)                return 2'b11;
    return 2'b00;
  endfunction

  always_comb begin
    mem_write       = d_mem_write & ~stall;
    reg_write       = d_reg_write & ~stall;
    push            = d_push & ~stall;
    pop             = d_pop & ~stall;
    write_c         = d_wflags & ~stall;
    write_z         = d_wflags & ~stall;
    alu_use_carry   = d_carry;
    alu_B_mux       = d_bmux;
    reg_B_mux       = d_rbmux;
    select_c        = d_sel;
    select_z        = d_sel;
    alu_op          = d_alu_op;
    pc_mux          = d_pc_mux;
    reg_write_mux   = d_rwm;
    forward_A       = fwd_sel(id_ex.rs, ex_mem, mem_wb);
    forward_B       = ID_EX_alu_B_mux ? 2'b01 : fwd_sel(id_ex.rt, ex_mem, mem_wb);
    forward_mem_MEM = ex_mem.st_fwd;
    IF_ID_loadbar   = stall;
    pc_writebar     = stall;
    ID_EX_flush     = stall;
    IF_ID_flush     = taken;
    if (!reset) begin
      mem_write       = 1'b0;
      reg_write       = 1'b0;
      push            = 1'b0;
      pop             = 1'b0;
      write_c         = 1'b0;
      write_z         = 1'b0;
      alu_use_carry   = 1'b0;
      alu_B_mux       = 1'b0;
      reg_B_mux       = 1'b0;
      select_c        = 1'b0;
      select_z        = 1'b0;
      alu_op          = 3'b000;
      pc_mux          = 2'b00;
      reg_write_mux   = 2'b00;
      forward_A       = 2'b00;
      forward_B       = 2'b00;
      forward_mem_MEM = 1'b0;
      IF_ID_loadbar   = 1'b0;
      pc_writebar     = 1'b0;
      ID_EX_flush     = 1'b1;
      IF_ID_flush     = 1'b1;
    end
  end

  assign id_next = '{rd: rd, rs: rs, rt: rt, reg_write: d_reg_write, long_op: is_long,
                     is_ld: is_ld, st_fwd: st_fwd, wc: d_wflags, wz: d_wflags};

  always_ff @(posedge clk) begin
    if (!reset) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      id_ex  <= ID_EX_flush ? '0 : id_next;
      ex_mem <= id_ex;
      mem_wb <= ex_mem;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{IF_ID_instruction[4:0], mem_wb.rs, mem_wb.rt, mem_wb.long_op,
                         mem_wb.is_ld, mem_wb.st_fwd, mem_wb.wc, mem_wb.wz};

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: an instruction-level pipeline model predicts every output
// each cycle into a queue; a negedge monitor compares. Directed spot checks cover key cases.
module tb_pipeline_controller;

  localparam int W = 27;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] IF_ID_instruction;
  logic        C, Z, next_C, next_Z, ID_EX_alu_B_mux;
  logic        mem_write, reg_write, push, pop, alu_use_carry, alu_B_mux, reg_B_mux;
  logic        select_c, select_z, write_c, write_z;
  logic [2:0]  alu_op;
  logic [1:0]  pc_mux, reg_write_mux, forward_A, forward_B;
  logic        forward_mem_MEM, IF_ID_loadbar, pc_writebar, ID_EX_flush, IF_ID_flush;

  always #5 clk = ~clk;

  pipeline_controller dut (
    .clk(clk), .reset(reset), .IF_ID_instruction(IF_ID_instruction),
    .C(C), .Z(Z), .next_C(next_C), .next_Z(next_Z), .ID_EX_alu_B_mux(ID_EX_alu_B_mux),
    .mem_write(mem_write), .reg_write(reg_write), .push(push), .pop(pop),
    .alu_use_carry(alu_use_carry), .alu_B_mux(alu_B_mux), .reg_B_mux(reg_B_mux),
    .select_c(select_c), .select_z(select_z), .write_c(write_c), .write_z(write_z),
    .alu_op(alu_op), .pc_mux(pc_mux), .reg_write_mux(reg_write_mux),
    .forward_A(forward_A), .forward_B(forward_B), .forward_mem_MEM(forward_mem_MEM),
    .IF_ID_loadbar(IF_ID_loadbar), .pc_writebar(pc_writebar),
    .ID_EX_flush(ID_EX_flush), .IF_ID_flush(IF_ID_flush)
  );

  logic [W-1:0] act;
  assign act = {mem_write, reg_write, push, pop, alu_use_carry, alu_B_mux, reg_B_mux,
                select_c, select_z, write_c, write_z, alu_op, pc_mux, reg_write_mux,
                forward_A, forward_B, forward_mem_MEM, IF_ID_loadbar, pc_writebar,
                ID_EX_flush, IF_ID_flush};

  // ---------------- reference model: instructions flowing through EX/MEM/WB
  typedef enum int {K_BUB, K_RALU, K_IALU, K_LD, K_ST, K_SH, K_JMP, K_BR, K_CALL, K_RET} kind_t;
  typedef struct {
    kind_t kind;
    int    rd;
    int    rs;
    int    rt;
    bit    sfwd;
  } rec_t;

  rec_t ex_r, mem_r, wb_r;
  bit   m_stall;
  logic [18:0] cur_ins;
  bit   cur_rst;

  function automatic rec_t bubble();
    rec_t r;
    r.kind = K_BUB; r.rd = 0; r.rs = 0; r.rt = 0; r.sfwd = 1'b0;
    return r;
  endfunction

  function automatic kind_t kind_of(input logic [18:0] ins);
    kind_t k;
    int top, sub;
    top = ins[18:16];
    sub = ins[15:14];
    if (top <= 1)      k = K_RALU;
    else if (top <= 3) k = K_IALU;
    else if (top == 4) k = K_LD;
    else if (top == 5) k = K_ST;
    else if (top == 6) k = K_SH;
    else if (sub == 0) k = K_JMP;
    else if (sub == 1) k = K_BR;
    else if (sub == 2) k = K_CALL;
    else               k = K_RET;
    return k;
  endfunction

  function automatic bit writes(input kind_t k);
    return k == K_RALU || k == K_IALU || k == K_LD || k == K_SH;
  endfunction

  function automatic bit is_long(input kind_t k);
    return k == K_LD || k == K_SH;
  endfunction

  function automatic bit sets_flags(input kind_t k);
    return k == K_RALU || k == K_IALU || k == K_SH;
  endfunction

  function automatic bit [1:0] fwd_of(input int src);
    if (writes(mem_r.kind) && !is_long(mem_r.kind) && mem_r.rd == src) return 2'b10;
    if (writes(wb_r.kind) && wb_r.rd == src) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [W-1:0] predict(input logic [18:0] ins, input bit rst,
                                           input bit c, input bit z, input bit nc,
                                           input bit nz, input bit bmux, output bit stall);
    kind_t k;
    int rd, rs, rt, cond;
    bit reads_rs, reads_rt, mw, rw, ps, pp, cy, bm, rbm, sel, wcz, fmm, zf, cf, tk;
    bit [2:0] aop;
    bit [1:0] pcm, rwm, fa, fb;
    k  = kind_of(ins);
    rd = ins[13:11]; rs = ins[10:8]; rt = ins[7:5]; cond = ins[13:12];
    reads_rs = k == K_RALU || k == K_IALU || k == K_LD || k == K_ST || k == K_SH;
    reads_rt = k == K_RALU;
    stall = (writes(ex_r.kind) && is_long(ex_r.kind) &&
             ((reads_rs && ex_r.rd == rs) || (reads_rt && ex_r.rd == rt))) ||
            (k == K_ST && ((writes(ex_r.kind) && ex_r.kind != K_LD && ex_r.rd == rd) ||
                           (writes(mem_r.kind) && mem_r.rd == rd)));
    mw  = k == K_ST;
    rw  = writes(k);
    ps  = k == K_CALL;
    pp  = k == K_RET;
    wcz = sets_flags(k);
    aop = (k == K_RALU || k == K_IALU) ? ins[16:14] : 3'b000;
    cy  = (k == K_RALU || k == K_IALU) && (aop == 3'd1 || aop == 3'd3);
    bm  = k == K_IALU || k == K_LD || k == K_ST;
    rbm = k == K_ST;
    sel = k == K_SH;
    rwm = (k == K_LD) ? 2'b10 : (k == K_SH) ? 2'b01 : 2'b00;
    zf  = sets_flags(ex_r.kind) ? nz : z;
    cf  = sets_flags(ex_r.kind) ? nc : c;
    tk  = (cond == 0) ? zf : (cond == 1) ? !zf : (cond == 2) ? cf : !cf;
    if (k == K_JMP || k == K_CALL) pcm = 2'b10;
    else if (k == K_RET)           pcm = 2'b11;
    else if (k == K_BR && tk)      pcm = 2'b01;
    else                           pcm = 2'b00;
    fa  = fwd_of(ex_r.rs);
    fb  = bmux ? 2'b01 : fwd_of(ex_r.rt);
    fmm = mem_r.sfwd;
    if (stall) begin
      mw = 0; rw = 0; ps = 0; pp = 0; wcz = 0;
    end
    if (!rst) begin
      stall = 0;
      return {{(W-2){1'b0}}, 2'b11};
    end
    return {mw, rw, ps, pp, cy, bm, rbm, sel, sel, wcz, wcz, aop, pcm, rwm, fa, fb, fmm,
            stall, stall, stall, pcm != 2'b00};
  endfunction

  task automatic advance(input logic [18:0] ins, input bit rst, input bit stall);
    rec_t n;
    if (!rst) begin
      ex_r = bubble(); mem_r = bubble(); wb_r = bubble();
    end else begin
      n.kind = kind_of(ins);
      n.rd = ins[13:11]; n.rs = ins[10:8]; n.rt = ins[7:5];
      n.sfwd = n.kind == K_ST && ex_r.kind == K_LD && ex_r.rd == n.rd;
      wb_r  = mem_r;
      mem_r = ex_r;
      ex_r  = stall ? bubble() : n;
    end
  endtask

  // ---------------- scoreboard
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] mon_e;
  string        mon_t;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      checks++;
      if (act !== mon_e) begin
        errors++;
        $display("FAIL %s: outputs got %07h expected %07h", mon_t, act, mon_e);
      end
    end
  end

  // ---------------- driver
  task automatic apply(input logic [18:0] ins, input bit rst, input bit c, input bit z,
                       input bit nc, input bit nz, input string tag);
    bit bm;
    bm = ex_r.kind == K_IALU || ex_r.kind == K_LD || ex_r.kind == K_ST;
    IF_ID_instruction = ins;
    reset = rst; C = c; Z = z; next_C = nc; next_Z = nz;
    ID_EX_alu_B_mux = bm;
    exp_q.push_back(predict(ins, rst, c, z, nc, nz, bm, m_stall));
    tag_q.push_back(tag);
    cur_ins = ins;
    cur_rst = rst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    advance(cur_ins, cur_rst, m_stall);
  endtask

  task automatic spot(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [18:0] enc(input int op, input int sub, input int rd,
                                      input int rs, input int rt, input int imm);
    return {op[2:0], sub[1:0], rd[2:0], rs[2:0], rt[2:0], imm[4:0]};
  endfunction

  function automatic logic [18:0] rand_ins();
    return enc($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31));
  endfunction

  logic [18:0] nop, i_add, i_sub, i_ld, i_use, i_ld5, i_st5, i_addi, i_bz, i_call, i_ret;
  logic [18:0] i_st6, i_add4, i_st4, r_ins;
  bit r_rst;

  initial begin
    ex_r = bubble(); mem_r = bubble(); wb_r = bubble();
    m_stall = 0;
    nop    = enc(2, 0, 7, 7, 0, 0);   // ADDI r7,r7,0
    i_add  = enc(0, 0, 1, 2, 3, 0);   // ADD r1,r2,r3
    i_sub  = enc(0, 2, 4, 1, 2, 0);   // SUB r4,r1,r2
    i_ld   = enc(4, 0, 1, 2, 0, 4);   // LD r1,[r2+4]
    i_use  = enc(0, 0, 3, 1, 1, 0);   // ADD r3,r1,r1
    i_ld5  = enc(4, 0, 5, 0, 0, 0);   // LD r5,[r0+0]
    i_st5  = enc(5, 0, 5, 0, 0, 8);   // ST r5,[r0+8]
    i_addi = enc(2, 0, 2, 2, 0, 0);   // ADDI r2,r2,0
    i_bz   = enc(7, 1, 0, 0, 0, 3);   // BZ +3
    i_call = enc(7, 2, 0, 0, 2, 0);   // CALL 0x040
    i_ret  = enc(7, 3, 0, 0, 0, 0);   // RET
    i_st6  = enc(5, 0, 6, 0, 0, 0);   // ST r6,[r0+0]
    i_add4 = enc(0, 0, 4, 2, 3, 0);   // ADD r4,r2,r3
    i_st4  = enc(5, 0, 4, 0, 0, 1);   // ST r4,[r0+1]

    @(posedge clk);
    #1;
    apply(nop, 0, 0, 0, 0, 0, "reset0"); #2;
    spot("reset_reg_write", reg_write, 0);
    spot("reset_id_ex_flush", ID_EX_flush, 1);
    spot("reset_if_id_flush", IF_ID_flush, 1);
    tick();
    apply(nop, 0, 0, 0, 0, 0, "reset1"); tick();
    for (int i = 0; i < 3; i++) begin apply(nop, 1, 0, 0, 0, 0, "fill"); tick(); end

    // distance-1 and distance-2 ALU forwarding
    apply(i_add, 1, 0, 0, 0, 0, "add"); tick();
    apply(i_sub, 1, 0, 0, 0, 0, "sub"); tick();
    apply(nop, 1, 0, 0, 0, 0, "sub_in_ex"); #2;
    spot("fwdA_exmem", forward_A, 2'b10);
    tick();
    apply(i_add, 1, 0, 0, 0, 0, "add2"); tick();
    apply(nop, 1, 0, 0, 0, 0, "gap"); tick();
    apply(i_sub, 1, 0, 0, 0, 0, "sub2"); tick();
    apply(nop, 1, 0, 0, 0, 0, "sub2_in_ex"); #2;
    spot("fwdA_memwb", forward_A, 2'b11);
    tick();

    // load-use: one bubble, then WB forwarding on both operands
    apply(i_ld, 1, 0, 0, 0, 0, "ld"); tick();
    apply(i_use, 1, 0, 0, 0, 0, "use_stall"); #2;
    spot("lu_pc_writebar", pc_writebar, 1);
    spot("lu_loadbar", IF_ID_loadbar, 1);
    spot("lu_id_ex_flush", ID_EX_flush, 1);
    spot("lu_reg_write", reg_write, 0);
    tick();
    apply(i_use, 1, 0, 0, 0, 0, "use_go"); #2;
    spot("lu_released", pc_writebar, 0);
    tick();
    apply(nop, 1, 0, 0, 0, 0, "use_in_ex"); #2;
    spot("lu_fwdA", forward_A, 2'b11);
    spot("lu_fwdB", forward_B, 2'b11);
    tick();

    // load then store of the same register: no stall, MEM-stage store forwarding
    apply(i_ld5, 1, 0, 0, 0, 0, "ld5"); tick();
    apply(i_st5, 1, 0, 0, 0, 0, "st5"); #2;
    spot("stfwd_no_stall", pc_writebar, 0);
    tick();
    apply(nop, 1, 0, 0, 0, 0, "st5_ex"); #2;
    spot("stfwd_ex", forward_mem_MEM, 0);
    tick();
    apply(nop, 1, 0, 0, 0, 0, "st5_mem"); #2;
    spot("stfwd_mem", forward_mem_MEM, 1);
    tick();
    apply(nop, 1, 0, 0, 0, 0, "st5_wb"); #2;
    spot("stfwd_wb", forward_mem_MEM, 0);
    tick();

    // store interlock behind an ALU producer: two held cycles
    apply(i_add4, 1, 0, 0, 0, 0, "add4"); tick();
    apply(i_st4, 1, 0, 0, 0, 0, "st4_a"); #2;
    spot("stlock_1", pc_writebar, 1);
    tick();
    apply(i_st4, 1, 0, 0, 0, 0, "st4_b"); #2;
    spot("stlock_2", pc_writebar, 1);
    tick();
    apply(i_st4, 1, 0, 0, 0, 0, "st4_c"); #2;
    spot("stlock_done", pc_writebar, 0);
    spot("stlock_mem_write", mem_write, 1);
    tick();

    // branch flag source: in-flight flags vs committed flags
    apply(i_addi, 1, 0, 0, 0, 0, "addi"); tick();
    apply(i_bz, 1, 0, 0, 0, 1, "bz_taken"); #2;
    spot("bz_pc_mux", pc_mux, 2'b01);
    spot("bz_flush", IF_ID_flush, 1);
    tick();
    apply(i_st6, 1, 0, 0, 0, 0, "st6"); tick();
    apply(i_bz, 1, 0, 0, 0, 1, "bz_not_taken"); #2;
    spot("bz_nt_pc_mux", pc_mux, 2'b00);
    spot("bz_nt_flush", IF_ID_flush, 0);
    tick();

    apply(i_call, 1, 0, 0, 0, 0, "call"); #2;
    spot("call_pc_mux", pc_mux, 2'b10);
    spot("call_push", push, 1);
    spot("call_flush", IF_ID_flush, 1);
    tick();
    apply(nop, 1, 0, 0, 0, 0, "body"); tick();
    apply(i_ret, 1, 0, 0, 0, 0, "ret"); #2;
    spot("ret_pc_mux", pc_mux, 2'b11);
    spot("ret_pop", pop, 1);
    tick();

    // reset held across a load-use stall
    apply(i_ld, 1, 0, 0, 0, 0, "ld_r"); tick();
    apply(i_use, 1, 0, 0, 0, 0, "use_r_stall"); tick();
    for (int i = 0; i < 2; i++) begin
      apply(i_use, 0, 0, 0, 0, 0, "reset_mid"); #2;
      spot("rst_reg_write", reg_write, 0);
      spot("rst_pc_writebar", pc_writebar, 0);
      spot("rst_flushes", {ID_EX_flush, IF_ID_flush}, 2'b11);
      tick();
    end
    apply(i_use, 1, 0, 0, 0, 0, "after_reset"); #2;
    spot("post_rst_stall", pc_writebar, 0);
    spot("post_rst_fwdA", forward_A, 2'b00);
    spot("post_rst_fwdB", forward_B, 2'b00);
    tick();

    // randomized traffic; a stalled instruction is re-presented as IF would
    r_ins = rand_ins();
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 99) != 0);
      if (!m_stall) r_ins = rand_ins();
      apply(r_ins, r_rst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
      tick();
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Decode and hazard controller that drives every control input of the 5-stage 19-bit datapath (IF/ID/EX/MEM/WB). It decodes `IF_ID_instruction` in ID and keeps shadow copies of the ID_EX, EX_MEM and MEM_WB destination information. From these it generates forwarding selects, load/shift-use stalls, store-data interlocks, taken-branch/jump/call/ret redirection and IF_ID flushes. It is the control-side counterpart of the datapath.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; `reset`=0 on a rising edge clears all state.
- IF_ID_instruction  in  19  instruction in ID.
- C, Z  in  1  committed flags.
- next_C, next_Z  in  1  flags being produced by the EX-stage instruction.
- ID_EX_alu_B_mux  in  1  EX instruction uses immediate.
- mem_write, reg_write, push, pop, alu_use_carry, alu_B_mux, reg_B_mux, select_c, select_z, write_c, write_z  out  1  ID-stage controls.
- alu_op  out  3; pc_mux, reg_write_mux  out  2.
- forward_A, forward_B  out  2  EX operand selects: 00 reg, 01 imm (B only), 10 EX_MEM ALU, 11 WB data.
- forward_mem_MEM  out  1  store data taken from MEM_WB load data.
- IF_ID_loadbar, pc_writebar  out  1  active-low holds; 1 = hold.
- ID_EX_flush, IF_ID_flush  out  1  insert bubble.

## Operation

**Decode (bits [18:16] / [18:14])**

Register fields: rd=[13:11], rs=[10:8], rt=[7:5].

- 00x R-ALU: reg_write, alu_op=[16:14], write_c/z.
  - alu_use_carry=1 for alu_op 001 or 011.
- 01x I-ALU: as R-ALU, plus alu_B_mux=1.
- 100 LD: alu_op=000, alu_B_mux=1, reg_write, reg_write_mux=10.
- 101 ST: alu_op=000, alu_B_mux=1, reg_B_mux=1, mem_write. Store data register is rd.
- 110 SHIFT: reg_write, reg_write_mux=01, select_c=select_z=1, write_c/z.
- 11100 JMP: pc_mux=10.
- 11101 BR: cond=[13:12] (00 Z, 01 !Z, 10 C, 11 !C).
  - Taken: pc_mux=01.
  - Flag source: if the shadow ID_EX write_c/write_z is set, the corresponding flag comes from next_C/next_Z; otherwise from C/Z.
- 11110 CALL: pc_mux=10, push.
- 11111 RET: pc_mux=11, pop.
- All other cases: pc_mux=00.
- Unused controls are 0.

**Source-register usage:** rs is used by types 00, 01, 100, 101 and 110. rt is used by type 00 only.

**Shadow pipeline** (registered at each edge):
- ID_EX ← {rd, rs, rt, reg_write, long, is_ld, st_fwd}, where long = LD or SHIFT.
- The ID_EX stage is loaded with zeros whenever ID_EX_flush=1.
- EX_MEM ← ID_EX; MEM_WB ← EX_MEM.

**Stall** (pc_writebar=1, IF_ID_loadbar=1, ID_EX_flush=1, all ID write enables 0) when either:
- Load/shift-use: the shadow ID_EX entry is long with reg_write, and its rd equals a used rs or rt of the ID instruction.
- Store interlock: the ID instruction is ST and its rd matches the rd of a reg_write entry that is either:
  - a non-LD entry in the shadow ID_EX, or
  - any entry in the shadow EX_MEM.

**Store forward:** if the ID instruction is ST and its rd equals the rd of an LD in the shadow ID_EX, there is no stall. st_fwd=1 is captured, and forward_mem_MEM = shadow EX_MEM st_fwd.

**Forwarding for A** (EX source rs):
- 10 when the EX_MEM entry has reg_write, is not long, and its rd matches.
- Otherwise 11 when the MEM_WB entry has reg_write and its rd matches.
- Otherwise 00.

**Forwarding for B:**
- 01 when ID_EX_alu_B_mux=1.
- Otherwise same rule as A, using rt.

**Redirect:** a taken JMP/BR/CALL/RET asserts IF_ID_flush=1 in the same cycle. Redirect and stall are mutually exclusive, because control instructions read no registers.

**Distance-3 hazards:** RegFile write-through resolves these; this block takes no action.

## Timing
- Decode outputs, stalls and forwards are combinational from inputs and shadow state.
- Shadow state is the only sequential element.
- While reset=0:
  - mem_write, reg_write, push, pop, write_c and write_z are 0.
  - ID_EX_flush=IF_ID_flush=1.
  - All other outputs are 0.
  - Shadow registers clear at the edge.
- Load-use penalty: exactly 1 bubble. The consumer then sees forward=11.
- Store interlock: holds until the producer leaves EX_MEM, at most 2 cycles.
- Taken control transfer: 1-cycle penalty (one flushed IF_ID slot).
- Reset deasserted mid-stall: stall state is lost and execution resumes from a clean shadow pipeline.

## Test plan
- ADD r1,r2,r3 then SUB r4,r1,r2 → with SUB in EX, forward_A=10. With a NOP between them, forward_A=11.
- LD r1,[r2+4] then ADD r3,r1,r1 → one cycle with pc_writebar=1, IF_ID_loadbar=1, ID_EX_flush=1. The next cycle has forward_A=forward_B=11.
- LD r5 then ST r5,[r0+8] → no stall; forward_mem_MEM=1 exactly when ST is in MEM.
- ADDI r2,r2,0 (Z result) immediately followed by BZ +3 with C=Z=0, next_Z=1 → taken, pc_mux=01, IF_ID_flush=1.
- CALL 0x040 → pc_mux=10, push=1, IF_ID_flush=1. A later RET → pc_mux=11, pop=1.
- reset=0 held for 2 cycles during a load-use stall → write enables 0, both flushes 1. After release, no forward or stall is asserted until new instructions flow.
